// File: rtl/swap_sequencer.sv
// swap_sequencer: runs NUM_STAGES processing stages in strict order, then
// requests a buffer swap and loops back to stage 0 while enable stays high.
// Each stage has a start/start_ack handshake and a synchronised done level.
// The done level is converted into a single-cycle rising-edge event.
// A frame counter counts completed swaps.
// Optional per-stage watchdog: define SWAP_SEQ_WATCHDOG_EN.
//
// Handshakes: start[i] and swap are request levels. Each is held until the
// cycle where it is high together with its ack. That handshake edge retires
// the request, and the request is low in the following cycle. An ack that
// arrives while its request is low is ignored.
module swap_sequencer #(
    parameter int NUM_STAGES  = 2,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_W   = 24,
    parameter int FCNT_W      = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    output logic [NUM_STAGES-1:0] start,
    input  logic [NUM_STAGES-1:0] start_ack,
    input  logic [NUM_STAGES-1:0] done,
    output logic [NUM_STAGES-1:0] done_ack,
    output logic                  swap,
    input  logic                  swap_ack,
    output logic                  busy,
    output logic [2:0]            stage,
    output logic [FCNT_W-1:0]     frame_count,
    input  logic [TIMEOUT_W-1:0]  timeout_limit,
    output logic                  timeout,
    input  logic                  clear_err,
    output logic [1:0]            state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_SWAP  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [2:0]            cur_q, cur_d;
    logic                  enable_q;
    logic [NUM_STAGES-1:0] sync_q [SYNC_STAGES];
    logic [NUM_STAGES-1:0] done_dly_q;
    logic [NUM_STAGES-1:0] done_edge;
    logic [NUM_STAGES-1:0] cur_onehot;
    logic                  start_hit;
    logic                  done_hit;
    logic                  last_stage;
    logic                  wd_fire;
    logic                  err_block;

    // Done synchronisers and edge-detect delay flops; these run in every state.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
            done_dly_q <= '0;
        end else begin
            sync_q[0] <= done;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
            done_dly_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign done_ack  = sync_q[SYNC_STAGES-1];
    assign done_edge = done_ack & ~done_dly_q;

    // Registered run request, so no input reaches an output combinationally.
    always_ff @(posedge clock) begin
        if (reset) enable_q <= 1'b0;
        else       enable_q <= enable;
    end

    // One-hot decode of the active stage index.
    always_comb begin
        cur_onehot = '0;
        for (int i = 0; i < NUM_STAGES; i++) cur_onehot[i] = (cur_q == 3'(i));
    end

    assign start_hit  = |(start_ack & cur_onehot);
    assign done_hit   = |(done_edge & cur_onehot);
    assign last_stage = (cur_q == 3'(NUM_STAGES - 1));

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            cur_q   <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
        end
    end

    // Next-state logic; a watchdog firing overrides every other transition.
    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        case (state_q)
            S_IDLE: begin
                if (enable_q && !err_block) begin
                    state_d = S_START;
                    cur_d   = '0;
                end
            end
            S_START: begin
                if (start_hit) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (done_hit) begin
                    if (last_stage) begin
                        state_d = S_SWAP;
                        cur_d   = '0;
                    end else begin
                        state_d = S_START;
                        cur_d   = cur_q + 3'd1;
                    end
                end
            end
            S_SWAP: begin
                if (swap_ack) begin
                    state_d = enable_q ? S_START : S_IDLE;
                    cur_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                cur_d   = '0;
            end
        endcase
        if (wd_fire) begin
            state_d = S_IDLE;
            cur_d   = '0;
        end
    end

    // Outputs decoded from registered state only.
    always_comb begin
        start     = (state_q == S_START) ? cur_onehot : '0;
        swap      = (state_q == S_SWAP);
        busy      = (state_q != S_IDLE);
        stage     = (state_q == S_START || state_q == S_WAIT) ? cur_q : 3'd0;
        state_dbg = state_q;
    end

    // Frame counter advances on the swap handshake edge and wraps naturally.
    always_ff @(posedge clock) begin
        if (reset)                             frame_count <= '0;
        else if (state_q == S_SWAP && swap_ack) frame_count <= frame_count + 1'b1;
    end

`ifdef SWAP_SEQ_WATCHDOG_EN
    logic [TIMEOUT_W-1:0] wd_cnt_q;
    logic                 in_stage;
    logic                 wd_enter;

    assign in_stage  = (state_q == S_START) || (state_q == S_WAIT);
    assign wd_enter  = ((state_d == S_START) || (state_d == S_WAIT)) &&
                       ((state_d != state_q) || (cur_d != cur_q));
    // Counter value k means k cycles have passed since entry, so the limit is
    // reached on the edge where the count would step to timeout_limit.
    assign wd_fire   = in_stage && (timeout_limit != '0) &&
                       (wd_cnt_q == timeout_limit - TIMEOUT_W'(1));
    assign err_block = timeout;

    // Per-state cycle counter and sticky error flag; firing beats clear_err.
    always_ff @(posedge clock) begin
        if (reset) begin
            wd_cnt_q <= '0;
            timeout  <= 1'b0;
        end else begin
            if (wd_enter)      wd_cnt_q <= '0;
            else if (in_stage) wd_cnt_q <= wd_cnt_q + 1'b1;
            if (wd_fire)        timeout <= 1'b1;
            else if (clear_err) timeout <= 1'b0;
        end
    end
`else
    logic unused_wd_inputs;

    assign unused_wd_inputs = ^{timeout_limit, clear_err};
    assign wd_fire          = 1'b0;
    assign err_block        = 1'b0;
    assign timeout          = 1'b0;
`endif

endmodule

// File: tb/tb_swap_sequencer.sv
// Directed testbench for swap_sequencer (NUM_STAGES=3, SYNC_STAGES=2, FCNT_W=4).
// Start and swap requests are acked one cycle after they appear. A scoreboard
// queue holds the expected order of {swap, start} request codes.
module tb_swap_sequencer;
  localparam int NS = 3;
  localparam int SS = 2;
  localparam int TW = 24;
  localparam int FW = 4;

  logic          clock;
  logic          reset;
  logic          enable;
  logic [NS-1:0] start;
  logic [NS-1:0] start_ack;
  logic [NS-1:0] done;
  logic [NS-1:0] done_ack;
  logic          swap;
  logic          swap_ack;
  logic          busy;
  logic [2:0]    stage;
  logic [FW-1:0] frame_count;
  logic [TW-1:0] timeout_limit;
  logic          timeout;
  logic          clear_err;
  logic [1:0]    state_dbg;

  logic [NS:0]   exp_q[$];
  logic [NS:0]   prev_ev;
  logic          auto_ack;
  int            n_checks;
  int            n_pass;

  swap_sequencer #(
    .NUM_STAGES (NS),
    .SYNC_STAGES(SS),
    .TIMEOUT_W  (TW),
    .FCNT_W     (FW)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .start        (start),
    .start_ack    (start_ack),
    .done         (done),
    .done_ack     (done_ack),
    .swap         (swap),
    .swap_ack     (swap_ack),
    .busy         (busy),
    .stage        (stage),
    .frame_count  (frame_count),
    .timeout_limit(timeout_limit),
    .timeout      (timeout),
    .clear_err    (clear_err),
    .state_dbg    (state_dbg)
  );

  // Clock and reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [NS-1:0] oh(input int i);
    oh = NS'(1) << i;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance to the next falling edge, drive acks, check invariants, run the scoreboard.
  task automatic tick();
    logic [NS:0] ev;
    @(negedge clock);
    start_ack = auto_ack ? start : '0;
    swap_ack  = auto_ack & swap;
    check("start_onehot", 32'($onehot0(start)), 32'd1);
    check("swap_start_excl", 32'(swap & (|start)), 32'd0);
    ev = {swap, start};
    if (ev != '0 && ev != prev_ev) begin
      if (exp_q.size() == 0) check("sb_unexpected", 32'(ev), 32'd0);
      else check("sb_event", 32'(ev), 32'(exp_q.pop_front()));
    end
    prev_ev = ev;
  endtask

  // Raise done[i] while in WAIT(i) and check the synchroniser latency.
  // Leaves done[i] high; returns one cycle after the next request appeared.
  task automatic stage_done(input int i, input logic [FW-1:0] exp_fc);
    logic last;
    last = (i == NS - 1);
    if (last) begin
      exp_q.push_back({1'b1, {NS{1'b0}}});
      if (enable) exp_q.push_back({1'b0, oh(0)});
    end else begin
      exp_q.push_back({1'b0, oh(i + 1)});
    end
    done[i] = 1'b1;
    tick();
    check("sync_first_flop", 32'(done_ack[i]), 32'd0);
    check("sync_start_low", 32'(start), 32'd0);
    tick();
    check("done_ack_bit", 32'(done_ack[i]), 32'd1);
    check("edge_start_low", 32'(start | {NS{swap}}), 32'd0);
    tick();
    if (last) check("swap_req", 32'(swap), 32'd1);
    else      check("next_start", 32'(start), 32'(oh(i + 1)));
    tick();
    if (last) begin
      check("swap_drop", 32'(swap), 32'd0);
      check("frame_count", 32'(frame_count), 32'(exp_fc));
      check("restart", 32'(start), enable ? 32'(oh(0)) : 32'd0);
      check("busy_after_swap", 32'(busy), 32'(enable));
    end else begin
      check("next_wait_stage", 32'(stage), 32'(i + 1));
      check("next_start_drop", 32'(start), 32'd0);
    end
  endtask

  // One full frame starting in WAIT(0); done pulses are 10 cycles long.
  task automatic run_frame(input logic [FW-1:0] exp_fc, input logic stop);
    check("frame_entry_stage", 32'(stage), 32'd0);
    check("frame_entry_busy", 32'(busy), 32'd1);
    for (int i = 0; i < NS; i++) begin
      if (stop && i == 1) enable = 1'b0;
      stage_done(i, exp_fc);
      repeat (6) tick();
      done[i] = 1'b0;
    end
  endtask

  initial begin
    n_checks      = 0;
    n_pass        = 0;
    reset         = 1'b1;
    enable        = 1'b0;
    done          = '0;
    clear_err     = 1'b0;
    timeout_limit = '0;
    start_ack     = '0;
    swap_ack      = 1'b0;
    auto_ack      = 1'b1;
    prev_ev       = '0;

    // Reset values
    repeat (3) tick();
    check("rst_start", 32'(start), 32'd0);
    check("rst_swap", 32'(swap), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_stage", 32'(stage), 32'd0);
    check("rst_done_ack", 32'(done_ack), 32'd0);
    check("rst_frame_count", 32'(frame_count), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);
    reset = 1'b0;
    repeat (2) tick();
    check("idle_hold", 32'(busy), 32'd0);

    // Enable to start: two edges
    enable = 1'b1;
    exp_q.push_back({1'b0, oh(0)});
    tick();
    check("en_first_edge", 32'(start), 32'd0);
    tick();
    check("en_start0", 32'(start), 32'(oh(0)));
    check("en_busy", 32'(busy), 32'd1);
    tick();
    check("start0_drop", 32'(start), 32'd0);
    check("wait0_stage", 32'(stage), 32'd0);

    // Normal loop, three frames
    for (int f = 1; f <= 3; f++) run_frame(FW'(f), 1'b0);

    // Stuck done[1] and spurious done[2] during WAIT(0)
    exp_q.push_back({1'b0, oh(1)});
    done[2] = 1'b1;
    repeat (4) tick();
    check("spurious_done_ack", 32'(done_ack[2]), 32'd1);
    check("spurious_stage", 32'(stage), 32'd0);
    check("spurious_start", 32'(start | {NS{swap}}), 32'd0);
    done[2] = 1'b0;
    done[1] = 1'b1;
    repeat (3) tick();
    void'(exp_q.pop_back());
    stage_done(0, FW'(0));
    repeat (6) tick();
    done[0] = 1'b0;
    check("stuck_stage", 32'(stage), 32'd1);
    check("stuck_start", 32'(start | {NS{swap}}), 32'd0);
    done[1] = 1'b0;
    repeat (3) tick();
    check("stuck_still_waiting", 32'(stage), 32'd1);
    stage_done(1, FW'(0));
    repeat (6) tick();
    done[1] = 1'b0;
    stage_done(2, FW'(4));
    repeat (6) tick();
    done[2] = 1'b0;

    // Stop at swap: enable dropped during WAIT(1)
    run_frame(FW'(5), 1'b1);
    check("stop_busy", 32'(busy), 32'd0);
    check("stop_state", 32'(state_dbg), 32'd0);
    check("stop_frame_count", 32'(frame_count), 32'd5);

    // Reset mid-frame in WAIT(1)
    enable = 1'b1;
    exp_q.push_back({1'b0, oh(0)});
    repeat (3) tick();
    stage_done(0, FW'(0));
    reset = 1'b1;
    tick();
    check("mid_rst_start", 32'(start), 32'd0);
    check("mid_rst_swap", 32'(swap), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_stage", 32'(stage), 32'd0);
    check("mid_rst_done_ack", 32'(done_ack), 32'd0);
    check("mid_rst_frame_count", 32'(frame_count), 32'd0);
    done[0] = 1'b0;
    tick();
    reset = 1'b0;
    exp_q.push_back({1'b0, oh(0)});
    tick();
    check("post_rst_first", 32'(start), 32'd0);
    tick();
    check("post_rst_start0", 32'(start), 32'(oh(0)));
    tick();

    // Counter wrap: 17 frames on a 4-bit counter
    for (int f = 1; f <= 17; f++) run_frame(FW'(f % 16), 1'b0);
    check("fcnt_wrap", 32'(frame_count), 32'd1);

    // Watchdog
    reset = 1'b1;
    timeout_limit = TW'(50);
    repeat (2) tick();
    reset = 1'b0;
    exp_q.push_back({1'b0, oh(0)});
    repeat (2) tick();
    check("wd_start0", 32'(start), 32'(oh(0)));
    tick();
    check("wd_wait0", 32'(busy), 32'd1);
    repeat (49) tick();
    check("wd_before_limit", 32'(timeout), 32'd0);
    check("wd_before_busy", 32'(busy), 32'd1);
    tick();
`ifdef SWAP_SEQ_WATCHDOG_EN
    check("wd_fired", 32'(timeout), 32'd1);
    check("wd_idle", 32'(busy), 32'd0);
    check("wd_start_clr", 32'(start), 32'd0);
    repeat (3) tick();
    check("wd_blocks_enable", 32'(busy), 32'd0);
    check("wd_sticky", 32'(timeout), 32'd1);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    check("wd_cleared", 32'(timeout), 32'd0);
    check("wd_clear_start", 32'(start), 32'd0);
    exp_q.push_back({1'b0, oh(0)});
    tick();
    check("wd_restart", 32'(start), 32'(oh(0)));
    timeout_limit = '0;
    repeat (100) tick();
    check("wd_zero_limit", 32'(timeout), 32'd0);
    check("wd_zero_busy", 32'(busy), 32'd1);
`else
    check("wd_absent_timeout", 32'(timeout), 32'd0);
    check("wd_absent_busy", 32'(busy), 32'd1);
    repeat (60) tick();
    check("wd_absent_late", 32'(timeout), 32'd0);
    check("wd_absent_stage", 32'(stage), 32'd0);
`endif

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
